// File: rtl/img_rom_arbiter.sv
// img_rom_arbiter
// Shares one byte-wide, synchronous-read RGB888 image ROM (3 bytes per pixel,
// rows stored bottom-up) between two pixel requesters. A granted request is
// turned into three consecutive byte reads; the assembled pixel is returned
// with a one-cycle acknowledge to the granted port.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req0/req1            level requests, held until ack
//   x0/y0, x1/y1         pixel coordinates, sampled at grant
//   ack0/ack1            one-cycle acknowledge; pix_* valid in that cycle
//   pix_r/pix_g/pix_b    returned pixel, held until the next ack
//   mem_addr, mem_rd     ROM byte address and read strobe
//   mem_data             ROM data, valid one cycle after the mem_rd cycle
//   busy                 high whenever the sequencer is not idle
//
// Build option
//   IMG_ARB_BOUNDS_CHECK_EN  out-of-range coordinates skip the ROM reads and
//                            return a zero pixel one cycle after the grant.

module img_rom_arbiter #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned HEIGHT = 32,
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req0,
   input  logic              req1,
   input  logic [9:0]        x0,
   input  logic [9:0]        y0,
   input  logic [9:0]        x1,
   input  logic [9:0]        y1,
   output logic              ack0,
   output logic              ack1,
   output logic [7:0]        pix_r,
   output logic [7:0]        pix_g,
   output logic [7:0]        pix_b,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              busy
);

   localparam int unsigned COORD_W = 10;
   localparam int unsigned BASE_W  = ADDR_W + 2;
   localparam logic [BASE_W-1:0] ROW_BYTES = BASE_W'(WIDTH * 3);
   localparam logic [BASE_W-1:0] TOP_ROW   = BASE_W'(HEIGHT - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_R,
      RD_G,
      RD_B,
      WAIT_B,
      ACK
   } state_t;

   state_t state;
   state_t state_next;

   logic              last_port;   // port served by the most recent grant
   logic              port_q;      // port owning the current transaction
   logic [ADDR_W-1:0] base_q;
   logic [7:0]        r_q;
   logic [7:0]        g_q;

   logic               grant;
   logic               grant_port;
   logic               port_d;
   logic               oob;
   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic [BASE_W-1:0]  base_full;
   logic [ADDR_W-1:0]  base_c;
   logic [ADDR_W-1:0]  addr_d;

   // Round-robin choice and byte address of the candidate pixel.
   // Bottom-up storage: image row y lives at ROM row HEIGHT-1-y.
   always_comb begin
      grant_port = req1;
      if (req0 && req1) begin
         grant_port = ~last_port;
      end
      sel_x     = grant_port ? x1 : x0;
      sel_y     = grant_port ? y1 : y0;
      base_full = ROW_BYTES * (TOP_ROW - BASE_W'(sel_y))
                + BASE_W'(3) * BASE_W'(sel_x);
      base_c    = ADDR_W'(base_full);
   end

`ifdef IMG_ARB_BOUNDS_CHECK_EN
   assign oob = (32'(sel_x) >= WIDTH) || (32'(sel_y) >= HEIGHT);
`else
   assign oob = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; arbitration happens only in IDLE.
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant      = 1'b1;
               state_next = oob ? ACK : RD_R;
            end
         end
         RD_R:    state_next = RD_G;
         RD_G:    state_next = RD_B;
         RD_B:    state_next = WAIT_B;
         WAIT_B:  state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so that they line up with
   // the state they belong to; mem_addr holds outside the read states.
   always_comb begin
      port_d = grant ? grant_port : port_q;
      case (state_next)
         RD_R:    addr_d = base_c;
         RD_G:    addr_d = base_q + ADDR_W'(1);
         RD_B:    addr_d = base_q + ADDR_W'(2);
         default: addr_d = mem_addr;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_port <= 1'b1;
         port_q    <= 1'b0;
         base_q    <= '0;
         r_q       <= '0;
         g_q       <= '0;
         pix_r     <= '0;
         pix_g     <= '0;
         pix_b     <= '0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (grant) begin
            last_port <= grant_port;
            port_q    <= grant_port;
            base_q    <= base_c;
         end
         // Read data trails the strobe by one cycle.
         if (state == RD_G) begin
            r_q <= mem_data;
         end
         if (state == RD_B) begin
            g_q <= mem_data;
         end
         if (state == WAIT_B) begin
            pix_r <= r_q;
            pix_g <= g_q;
            pix_b <= mem_data;
         end else if (grant && oob) begin
            pix_r <= '0;
            pix_g <= '0;
            pix_b <= '0;
         end
         mem_rd   <= (state_next == RD_R) || (state_next == RD_G) ||
                     (state_next == RD_B);
         mem_addr <= addr_d;
         ack0     <= (state_next == ACK) && !port_d;
         ack1     <= (state_next == ACK) && port_d;
         busy     <= (state_next != IDLE);
      end
   end

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Testbench for img_rom_arbiter: randomized and directed requests from both
// ports, a behavioural ROM, and a transaction-level reference model feeding a
// scoreboard of expected ROM addresses and acknowledged pixels.
`timescale 1ns/1ps

module tb_img_rom_arbiter;

   localparam int W        = 32;
   localparam int H        = 32;
   localparam int ADDR_W   = 12;
   localparam int ROM_SIZE = 1 << ADDR_W;

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic              req0 = 1'b0;
   logic              req1 = 1'b0;
   logic [9:0]        x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic              ack0, ack1;
   logic [7:0]        pix_r, pix_g, pix_b;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data = '0;
   logic              busy;

   img_rom_arbiter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rstn(rstn),
      .req0(req0), .req1(req1),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .ack0(ack0), .ack1(ack1),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous-read ROM, one cycle latency.
   logic [7:0] rom [ROM_SIZE];
   always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

   typedef struct {
      int port;
      int r, g, b;
      int ack_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   addr_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state.
   int cyc = 0;          // rising edges seen since reset release
   int next_free = 0;    // first edge at which a new grant may occur
   int busy_last = -1;   // last cycle (in cyc units) busy is expected high
   int last_served = 1;
   int m_p, m_x, m_y, m_base;
   bit m_oob;
   exp_t m_e;

   function automatic int wrap(input int v);
      return ((v % ROM_SIZE) + ROM_SIZE) % ROM_SIZE;
   endfunction

   function automatic int rand_coord();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(32, 1023));
      return int'($urandom_range(0, 31));
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic flag(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: got %0d with nothing expected (cycle %0d, t=%0t)", name, act, cyc, $time);
   endtask

   // Transaction-level model: one pixel served per decision slot, ack five
   // cycles after the grant (one cycle for a range-rejected grant).
   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         exp_q.delete();
         addr_q.delete();
         next_free   = 0;
         busy_last   = -1;
         last_served = 1;
      end else begin
         cyc++;
         if (cyc >= next_free && (req0 || req1)) begin
            m_p = (req0 && req1) ? 1 - last_served : (req1 ? 1 : 0);
            last_served = m_p;
            m_x = (m_p == 1) ? int'(x1) : int'(x0);
            m_y = (m_p == 1) ? int'(y1) : int'(y0);
            m_oob = 1'b0;
`ifdef IMG_ARB_BOUNDS_CHECK_EN
            m_oob = (m_x >= W) || (m_y >= H);
`endif
            m_base = wrap(W * 3 * (H - 1 - m_y) + 3 * m_x);
            if (m_oob) begin
               m_e = '{m_p, 0, 0, 0, cyc};
               next_free = cyc + 2;
               busy_last = cyc;
            end else begin
               for (int k = 0; k < 3; k++) addr_q.push_back(wrap(m_base + k));
               m_e = '{m_p, int'(rom[wrap(m_base)]), int'(rom[wrap(m_base + 1)]),
                       int'(rom[wrap(m_base + 2)]), cyc + 4};
               next_free = cyc + 6;
               busy_last = cyc + 4;
            end
            exp_q.push_back(m_e);
         end
      end
   end

   // Monitor: compares DUT activity with the scoreboard on falling edges.
   int   last_r = 0, last_g = 0, last_b = 0;
   exp_t mon_e;
   initial forever begin
      @(negedge clk);
      check("busy", int'(busy), (rstn && cyc <= busy_last) ? 1 : 0);
      if (mem_rd) begin
         if (addr_q.size() == 0) flag("mem_rd_unexpected", int'(mem_addr));
         else check("mem_addr", int'(mem_addr), addr_q.pop_front());
      end
      if (ack0 || ack1) begin
         if (exp_q.size() == 0) begin
            flag("ack_unexpected", int'({ack1, ack0}));
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_port", int'({ack1, ack0}), (mon_e.port == 1) ? 2 : 1);
            check("ack_cycle", cyc, mon_e.ack_cyc);
            check("pix_r", int'(pix_r), mon_e.r);
            check("pix_g", int'(pix_g), mon_e.g);
            check("pix_b", int'(pix_b), mon_e.b);
            last_r = mon_e.r;
            last_g = mon_e.g;
            last_b = mon_e.b;
         end
      end else begin
         if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
            flag("ack_missing", exp_q[0].port);
            void'(exp_q.pop_front());
         end
         if (!rstn) begin
            last_r = 0;
            last_g = 0;
            last_b = 0;
         end
         check("pix_hold", int'({pix_r, pix_g, pix_b}), (last_r << 16) | (last_g << 8) | last_b);
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"}, int'({ack1, ack0}), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_mem_rd"}, int'(mem_rd), 0);
      check({tag, "_mem_addr"}, int'(mem_addr), 0);
      check({tag, "_pix"}, int'({pix_r, pix_g, pix_b}), 0);
   endtask

   // Waits (bounded) for the port's ack, then returns just after the edge
   // that ends the ack cycle.
   task automatic wait_ack(input int p);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (p == 0) ? ack0 : ack1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: port %0d got no ack, required one within 40 cycles", p);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input int p, input int x, input int y);
      if (p == 0) begin
         req0 = 1'b1; x0 = 10'(x); y0 = 10'(y);
      end else begin
         req1 = 1'b1; x1 = 10'(y == y ? x : 0); y1 = 10'(y);
      end
      wait_ack(p);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   // Random requester for port 0; coordinates churn while waiting, so only
   // the value present at the grant edge may matter.
   task automatic drive0(input int n);
      bit seen;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         req0 = 1'b1; x0 = 10'(rand_coord()); y0 = 10'(rand_coord());
         seen = 1'b0;
         for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = ack0;
            if (!seen && $urandom_range(0, 3) == 0) x0 = 10'(rand_coord());
         end
         if (!seen) begin
            checks++; errors++;
            $display("FAIL drv0_timeout: got no ack0, required one within 60 cycles");
         end
         @(posedge clk); #1;
         req0 = 1'b0;
      end
   endtask

   task automatic drive1(input int n);
      bit seen;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         req1 = 1'b1; x1 = 10'(rand_coord()); y1 = 10'(rand_coord());
         seen = 1'b0;
         for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = ack1;
            if (!seen && $urandom_range(0, 3) == 0) y1 = 10'(rand_coord());
         end
         if (!seen) begin
            checks++; errors++;
            $display("FAIL drv1_timeout: got no ack1, required one within 60 cycles");
         end
         @(posedge clk); #1;
         req1 = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < ROM_SIZE; i++) rom[i] = 8'($urandom);

      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single requests, including corner pixels and an out-of-range x.
      do_req(0, 0, 0);
      do_req(1, 31, 31);
      do_req(0, 32, 5);
      repeat (2) begin @(posedge clk); #1; end

      // Simultaneous requests, each dropped after its own ack.
      fork
         do_req(0, 7, 3);
         do_req(1, 12, 30);
      join
      repeat (3) begin @(posedge clk); #1; end

      // Both held continuously: grants must alternate.
      req0 = 1'b1; x0 = 10'(5); y0 = 10'(9);
      req1 = 1'b1; x1 = 10'(20); y1 = 10'(1);
      repeat (24) @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (12) begin @(posedge clk); #1; end

      // Randomized contention from both ports.
      fork
         drive0(15);
         drive1(15);
      join
      repeat (8) begin @(posedge clk); #1; end

      // Request dropped in cycle 2 still completes.
      req0 = 1'b1; x0 = 10'(17); y0 = 10'(22);
      @(posedge clk);
      @(posedge clk); #1;
      req0 = 1'b0;
      wait_ack(0);
      repeat (8) begin @(posedge clk); #1; end

      // Reset during RD_G: outputs clear at once; port 0 favoured afterwards.
      req0 = 1'b1; x0 = 10'(3); y0 = 10'(4);
      @(posedge clk);
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero("midreset");
      req1 = 1'b1; x1 = 10'(9); y1 = 10'(11);
      repeat (2) @(posedge clk);
      #3;
      rstn = 1'b1;
      fork
         begin wait_ack(0); req0 = 1'b0; end
         begin wait_ack(1); req1 = 1'b0; end
      join

      repeat (10) begin @(posedge clk); #1; end
      check("exp_q_empty", exp_q.size(), 0);
      check("addr_q_empty", addr_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
